demux_stream: RTL and testbench

Streaming 1-to-4 demultiplexer, the inverse of the team's 4:1 selector. One input stream with a 2-bit route select is steered into one of four output channels a/b/c/d. Each output channel has a 2-entry FIFO, so a stalled consumer blocks only its own channel. Each channel also keeps a wrapping count of accepted words for debug.

---
 rtl/demux_stream_if.sv | 35 +++
 rtl/demux_stream.sv | 106 ++++++++++
 tb/tb_demux_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_if.sv
// Stream bundle for the 1-to-4 demux: one routed input stream, four output channels
// and the packed per-channel accept counters.
interface demux_stream_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
);
  logic [WIDTH-1:0] din;
  logic [1:0]       y;
  logic             din_valid;
  logic             din_ready;

  logic [WIDTH-1:0] dout_a, dout_b, dout_c, dout_d;
  logic             a_valid, b_valid, c_valid, d_valid;
  logic             a_ready, b_ready, c_ready, d_ready;

  logic [4*CW-1:0]  cnt;

  modport master (
    output din, y, din_valid,
    output a_ready, b_ready, c_ready, d_ready,
    input  din_ready,
    input  dout_a, dout_b, dout_c, dout_d,
    input  a_valid, b_valid, c_valid, d_valid,
    input  cnt
  );

  modport slave (
    input  din, y, din_valid,
    input  a_ready, b_ready, c_ready, d_ready,
    output din_ready,
    output dout_a, dout_b, dout_c, dout_d,
    output a_valid, b_valid, c_valid, d_valid,
    output cnt
  );
endinterface

// File: rtl/demux_stream.sv
// 1-to-4 stream demux with a 2-entry FWFT FIFO per channel; a write shows at dout 1 cycle later.
// din_ready drops only when the selected channel is full, so one stalled consumer blocks only its own channel.
module demux_stream #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input logic           clk,
  input logic           rst,
  demux_stream_if.slave s
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             occ_q  [4];
  occ_e             occ_d  [4];
  logic [WIDTH-1:0] head_q [4];
  logic [WIDTH-1:0] head_d [4];
  logic [WIDTH-1:0] tail_q [4];
  logic [WIDTH-1:0] tail_d [4];
  logic [CW-1:0]    cnt_q  [4];
  logic [CW-1:0]    cnt_d  [4];

  logic [3:0] rdy;
  logic [3:0] push;
  logic [3:0] pop;
  logic       in_fire;

  assign rdy         = {s.d_ready, s.c_ready, s.b_ready, s.a_ready};
  assign s.din_ready = !rst && (occ_q[s.y] != FULL);
  assign in_fire     = s.din_valid && s.din_ready;

  // head_q doubles as the registered dout and keeps the last popped word once empty.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      occ_d[i]  = occ_q[i];
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      cnt_d[i]  = cnt_q[i];
      push[i]   = in_fire && (s.y == 2'(i));
      pop[i]    = (occ_q[i] != EMPTY) && rdy[i];

      if (push[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end

      case (occ_q[i])
        EMPTY: begin
          if (push[i]) begin
            head_d[i] = s.din;
            occ_d[i]  = ONE;
          end
        end
        ONE: begin
          if (push[i] && pop[i]) begin
            head_d[i] = s.din;
          end else if (push[i]) begin
            tail_d[i] = s.din;
            occ_d[i]  = FULL;
          end else if (pop[i]) begin
            occ_d[i] = EMPTY;
          end
        end
        FULL: begin
          if (pop[i]) begin
            head_d[i] = tail_q[i];
            occ_d[i]  = ONE;
          end
        end
        default: occ_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        occ_q[i]  <= EMPTY;
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end else begin
        occ_q[i]  <= occ_d[i];
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign s.dout_a  = head_q[0];
  assign s.dout_b  = head_q[1];
  assign s.dout_c  = head_q[2];
  assign s.dout_d  = head_q[3];
  assign s.a_valid = (occ_q[0] != EMPTY);
  assign s.b_valid = (occ_q[1] != EMPTY);
  assign s.c_valid = (occ_q[2] != EMPTY);
  assign s.d_valid = (occ_q[3] != EMPTY);
  assign s.cnt     = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: inputs change 1 time unit after each rising edge,
// and outputs are checked in the same quiet window before the next edge.
module tb_demux_stream;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  demux_stream_if #(.WIDTH(4), .CW(8)) bus ();

  demux_stream #(.WIDTH(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic get_valid(input int k);
    case (k)
      0:       return bus.a_valid;
      1:       return bus.b_valid;
      2:       return bus.c_valid;
      default: return bus.d_valid;
    endcase
  endfunction

  function automatic logic [3:0] get_dout(input int k);
    case (k)
      0:       return bus.dout_a;
      1:       return bus.dout_b;
      2:       return bus.dout_c;
      default: return bus.dout_d;
    endcase
  endfunction

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.din       = '0;
    bus.y         = 2'd0;
    bus.din_valid = 1'b0;
    bus.a_ready   = 1'b0;
    bus.b_ready   = 1'b0;
    bus.c_ready   = 1'b0;
    bus.d_ready   = 1'b0;

    // Reset state
    step();
    step();
    check("rst_din_ready", 32'(bus.din_ready), 32'd0);
    check("rst_valids", 32'({bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid}), 32'd0);
    check("rst_douts", 32'({bus.dout_d, bus.dout_c, bus.dout_b, bus.dout_a}), 32'd0);
    check("rst_cnt", 32'(bus.cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_din_ready", 32'(bus.din_ready), 32'd1);

    // Single word to channel a
    bus.a_ready   = 1'b1;
    bus.din       = 4'h5;
    bus.y         = 2'd0;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    check("a1_valid", 32'(bus.a_valid), 32'd1);
    check("a1_dout", 32'(bus.dout_a), 32'h5);
    step();
    check("a1_valid_after_pop", 32'(bus.a_valid), 32'd0);
    check("a1_dout_hold", 32'(bus.dout_a), 32'h5);
    check("a1_cnt", 32'(bus.cnt[7:0]), 32'd1);

    // Route sweep, all consumers ready
    bus.b_ready = 1'b1;
    bus.c_ready = 1'b1;
    bus.d_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.din       = 4'(k + 1);
      bus.y         = 2'(k);
      bus.din_valid = 1'b1;
      step();
      check($sformatf("sweep_valid_%0d", k), 32'(get_valid(k)), 32'd1);
      check($sformatf("sweep_dout_%0d", k), 32'(get_dout(k)), 32'(k + 1));
    end
    bus.din_valid = 1'b0;
    step();
    check("sweep_valids_drained", 32'({bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid}), 32'd0);
    check("sweep_cnt", 32'(bus.cnt), 32'h01010102);

    // Backpressure on channel b
    bus.b_ready   = 1'b0;
    bus.y         = 2'd1;
    bus.din       = 4'h7;
    bus.din_valid = 1'b1;
    #1;
    check("bp_rdy_w1", 32'(bus.din_ready), 32'd1);
    step();
    bus.din = 4'h8;
    check("bp_rdy_w2", 32'(bus.din_ready), 32'd1);
    step();
    bus.din = 4'h9;
    #1;
    check("bp_rdy_full", 32'(bus.din_ready), 32'd0);
    bus.y   = 2'd0;
    bus.din = 4'hA;
    #1;
    check("bp_rdy_other_ch", 32'(bus.din_ready), 32'd1);
    step();
    check("bp_a_valid", 32'(bus.a_valid), 32'd1);
    check("bp_a_dout", 32'(bus.dout_a), 32'hA);
    check("bp_b_head", 32'(bus.dout_b), 32'h7);
    bus.y   = 2'd1;
    bus.din = 4'h9;
    #1;
    check("bp_rdy_still_full", 32'(bus.din_ready), 32'd0);
    bus.b_ready = 1'b1;
    #1;
    check("bp_rdy_ignores_ready", 32'(bus.din_ready), 32'd0);
    step();
    check("bp_drain_8", 32'(bus.dout_b), 32'h8);
    check("bp_rdy_reopen", 32'(bus.din_ready), 32'd1);
    step();
    bus.din_valid = 1'b0;
    check("bp_third_word", 32'(bus.dout_b), 32'h9);
    check("bp_third_valid", 32'(bus.b_valid), 32'd1);
    step();
    check("bp_b_empty", 32'(bus.b_valid), 32'd0);
    check("bp_cnt", 32'(bus.cnt), 32'h01010403);

    // Sustained push+pop in ONE on channel c
    bus.y         = 2'd2;
    bus.din_valid = 1'b1;
    for (int v = 0; v < 16; v++) begin
      bus.din = 4'(v);
      #1;
      check($sformatf("strm_rdy_%0d", v), 32'(bus.din_ready), 32'd1);
      step();
      check($sformatf("strm_dout_%0d", v), 32'({bus.c_valid, bus.dout_c}), 32'(16 + v));
    end
    bus.din_valid = 1'b0;
    step();
    check("strm_c_empty", 32'(bus.c_valid), 32'd0);
    check("strm_cnt", 32'(bus.cnt), 32'h01110403);

    // Counter wrap on channel d: 255 more words on top of the one already counted
    bus.y         = 2'd3;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      bus.din = 4'(i);
      step();
      if (i == 253) check("wrap_cnt_255", 32'(bus.cnt[31:24]), 32'd255);
    end
    bus.din_valid = 1'b0;
    step();
    check("wrap_cnt", 32'(bus.cnt), 32'h00110403);

    // Reset while channel a is full and stalled
    bus.a_ready   = 1'b0;
    bus.y         = 2'd0;
    bus.din       = 4'hB;
    bus.din_valid = 1'b1;
    step();
    bus.din = 4'hC;
    step();
    bus.din = 4'hD;
    check("mid_a_full_rdy", 32'(bus.din_ready), 32'd0);
    check("mid_a_head", 32'(bus.dout_a), 32'hB);
    rst = 1'b1;
    bus.a_ready = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(bus.din_ready), 32'd0);
    step();
    check("mid_a_valid", 32'(bus.a_valid), 32'd0);
    check("mid_a_dout", 32'(bus.dout_a), 32'd0);
    check("mid_cnt", 32'(bus.cnt), 32'd0);
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    check("mid_post_rdy", 32'(bus.din_ready), 32'd1);
    step();
    check("mid_no_ghost", 32'(bus.a_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
